// File: rtl/fpu_dispatch_if.sv
// Dispatch handshake between core hazard logic, the FPU sub-unit bank and the responder.
// The master side plays core plus sub-units; the responder takes the slave side.
interface fpu_dispatch_if #(
    parameter int NUM_UNITS = 4
);
    logic                      i_en_pulse;
    logic [1:0]                i_op_sel;
    logic [31:0]               i_src1;
    logic [31:0]               i_src2;
    logic [31:0]               i_src3;
    logic                      i_advance;
    logic [NUM_UNITS*32-1:0]   i_unit_result;
    logic [NUM_UNITS-1:0]      o_unit_start;
    logic [31:0]               o_unit_a;
    logic [31:0]               o_unit_b;
    logic [31:0]               o_unit_c;
    logic [31:0]               o_result;
    logic                      o_valid;
    logic                      o_busy;
    logic                      o_err_busy;
    logic                      o_err_op;

    modport master (
        output i_en_pulse, i_op_sel, i_src1, i_src2, i_src3, i_advance, i_unit_result,
        input  o_unit_start, o_unit_a, o_unit_b, o_unit_c, o_result, o_valid, o_busy,
               o_err_busy, o_err_op
    );

    modport slave (
        input  i_en_pulse, i_op_sel, i_src1, i_src2, i_src3, i_advance, i_unit_result,
        output o_unit_start, o_unit_a, o_unit_b, o_unit_c, o_result, o_valid, o_busy,
               o_err_busy, o_err_op
    );
endinterface

// File: rtl/fpu_dispatch_responder.sv
// Responder for the FPU enable/valid handshake: starts a fixed-latency sub-unit, times it,
// and holds the captured result valid until exec advances the dispatching instruction.
module fpu_dispatch_responder #(
    parameter int NUM_UNITS = 4,
    parameter int LAT0      = 10,
    parameter int LAT1      = 12,
    parameter int LAT2      = 3,
    parameter int LAT3      = 4,
    parameter int CNT_W     = 5
) (
    input logic           clk,
    input logic           rst,
    fpu_dispatch_if.slave bus
);
    localparam int PAD_W = 4 * 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [1:0]           r_sel;
    logic [NUM_UNITS-1:0] r_unit_start;
    logic [31:0]          r_unit_a;
    logic [31:0]          r_unit_b;
    logic [31:0]          r_unit_c;
    logic [31:0]          r_result;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_err_busy;
    logic                 r_err_op;

    logic [PAD_W-1:0]     w_res_pad;
    logic [31:0]          w_sel_result;
    logic                 w_op_legal;

    function automatic logic [CNT_W-1:0] lat_load(input logic [1:0] sel);
        case (sel)
            2'd0:    lat_load = CNT_W'(LAT0 - 1);
            2'd1:    lat_load = CNT_W'(LAT1 - 1);
            2'd2:    lat_load = CNT_W'(LAT2 - 1);
            2'd3:    lat_load = CNT_W'(LAT3 - 1);
            default: lat_load = {CNT_W{1'b0}};
        endcase
    endfunction

    // Zero-pad the result bus so the selector below is the same for any unit count.
    assign w_res_pad  = PAD_W'(bus.i_unit_result);
    assign w_op_legal = (3'(bus.i_op_sel) < 3'(NUM_UNITS));

    // Route the selected unit's result lane to the capture register.
    always_comb begin
        w_sel_result = 32'd0;
        case (r_sel)
            2'd0:    w_sel_result = w_res_pad[31:0];
            2'd1:    w_sel_result = w_res_pad[63:32];
            2'd2:    w_sel_result = w_res_pad[95:64];
            2'd3:    w_sel_result = w_res_pad[127:96];
            default: w_sel_result = 32'd0;
        endcase
    end

    // Dispatch FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= {CNT_W{1'b0}};
            r_sel        <= 2'd0;
            r_unit_start <= {NUM_UNITS{1'b0}};
            r_unit_a     <= 32'd0;
            r_unit_b     <= 32'd0;
            r_unit_c     <= 32'd0;
            r_result     <= 32'd0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_err_busy   <= 1'b0;
            r_err_op     <= 1'b0;
        end else begin
            r_unit_start <= {NUM_UNITS{1'b0}};
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_en_pulse) begin
                        if (w_op_legal) begin
                            r_unit_a     <= bus.i_src1;
                            r_unit_b     <= bus.i_src2;
                            r_unit_c     <= bus.i_src3;
                            r_unit_start <= NUM_UNITS'(1'b1) << bus.i_op_sel;
                            r_cnt        <= lat_load(bus.i_op_sel);
                            r_sel        <= bus.i_op_sel;
                            r_busy       <= 1'b1;
                            r_state      <= ST_RUN;
                        end else begin
                            // Illegal op completes at once with a zero result so the core never hangs.
                            r_err_op <= 1'b1;
                            r_result <= 32'd0;
                            r_valid  <= 1'b1;
                            r_busy   <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.i_en_pulse) begin
                        r_err_busy <= 1'b1;
                    end
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_result <= w_sel_result;
                        r_valid  <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1'b1);
                    end
                end
                ST_DONE: begin
                    if (bus.i_en_pulse) begin
                        r_err_busy <= 1'b1;
                    end
                    // Valid stays up until the instruction leaves exec, else hazard logic re-issues.
                    if (bus.i_advance) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_unit_start = r_unit_start;
    assign bus.o_unit_a     = r_unit_a;
    assign bus.o_unit_b     = r_unit_b;
    assign bus.o_unit_c     = r_unit_c;
    assign bus.o_result     = r_result;
    assign bus.o_valid      = r_valid;
    assign bus.o_busy       = r_busy;
    assign bus.o_err_busy   = r_err_busy;
    assign bus.o_err_op     = r_err_op;
endmodule

// File: doc/fpu_dispatch_responder.md
Name: fpu_dispatch_responder

Overview:
- Responder end of the core's FPU enable/valid handshake: sits between the core's hazard logic and a bank of fixed-latency FPU sub-units (fdiv, fsqrt, fcvt, fmul-add class).
- Accepts a one-cycle enable pulse and latches the operands and the op select.
- Times the selected unit's latency, captures its result, then holds `valid` and `result` stable until the core advances the dispatching instruction out of exec.
- One instance serves the slow FPU path and another serves the fast path; they differ only in parameters.

Parameters:
- NUM_UNITS, 4, number of attached sub-units (1..4)
- LAT0, 10, latency in cycles of unit 0 (start to result), >=1
- LAT1, 12, latency of unit 1, >=1
- LAT2, 3, latency of unit 2, >=1
- LAT3, 4, latency of unit 3, >=1
- CNT_W, 5, latency counter width; must hold max(LATk)-1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en_pulse  in  1  one-cycle dispatch request from hazard logic
- op_sel  in  2  sub-unit index, sampled with en_pulse
- src1  in  32  operand 1, sampled with en_pulse
- src2  in  32  operand 2, sampled with en_pulse
- src3  in  32  operand 3 (fused ops), sampled with en_pulse
- advance  in  1  exec stage advancing this cycle (~stall_e); releases held result
- unit_result  in  NUM_UNITS*32  packed sub-unit outputs; unit k at bits [32k+31:32k]
- unit_start  out  NUM_UNITS  one-hot, one-cycle start to the selected unit
- unit_a  out  32  latched operand 1 to all units
- unit_b  out  32  latched operand 2
- unit_c  out  32  latched operand 3
- result  out  32  captured result, stable while valid
- valid  out  1  result available; held until released
- busy  out  1  high in RUN or DONE
- err_busy  out  1  sticky: en_pulse arrived while not IDLE
- err_op  out  1  sticky: op_sel >= NUM_UNITS

Behaviour:
- Reset values: state=IDLE; unit_start=0, unit_a/b/c=0, result=0, valid=0, busy=0, err_busy=0, err_op=0, counter=0. Reset mid-operation aborts to IDLE with no valid.
- IDLE, en_pulse=1 at edge E0, op_sel=k<NUM_UNITS:
  - latch src1..3 into unit_a..c
  - unit_start[k]=1 for exactly the cycle after E0
  - counter=LATk-1; sel=k; go to RUN
- IDLE, en_pulse=1, op_sel>=NUM_UNITS: set err_op, result=0, valid=1, go to DONE. The core never hangs on an illegal op.
- RUN: counter decrements each edge. At the edge where counter==0: result<=unit_result[sel], valid<=1, go to DONE.
- Latency: valid rises after edge E0+LATk, so LATk=1 gives valid visible in the cycle after E0+1.
- DONE: valid and result are held.
  - At an edge with advance=1: valid<=0, go to IDLE.
  - advance=0 keeps DONE indefinitely. This covers cache stalls that hold exec while the FPU op sits there.
- Release rule: valid must not drop while the instruction remains in exec. Otherwise the hazard logic re-issues the op.
- Back-to-back: after release, a new en_pulse can be accepted on the very next edge.
- en_pulse while in RUN or DONE: ignored, err_busy set (sticky until rst).
- en_pulse together with advance in DONE: release takes effect and the pulse is ignored with err_busy set.
- advance in IDLE or RUN: no effect.
- busy = (state != IDLE).
- unit_a/b/c hold their values from capture until the next accepted en_pulse.

Test Plan:
- Reset: assert rst 2 cycles mid-RUN (op 1) -> next cycle valid=0, busy=0, err flags 0, unit_start=0; no valid appears later.
- Single op: en_pulse, op_sel=2, src1=0x3F800000, unit 2 drives 0x40000000 -> unit_start=4'b0100 for 1 cycle; valid rises exactly 3 edges after the sampling edge; result=0x40000000.
- Hold/release: op 0 completes, advance=0 for 5 cycles -> valid=1 and result stable throughout; advance=1 -> valid=0 next cycle, state IDLE.
- Back-to-back: release on edge N, en_pulse op 3 on edge N+1 -> accepted; valid after N+1+4; no err_busy.
- Overlap: en_pulse at edge E0 (op 1), second en_pulse at E0+5 -> ignored, err_busy=1; first result still delivered at E0+12.
- Illegal op: NUM_UNITS=2, en_pulse with op_sel=3 -> err_op=1, valid=1 next cycle with result=0; cleared by advance.
